game_clk_gen: RTL and testbench
===============================

# game_clk_gen

Parametrised game-tempo generator that divides the system clock into a square-wave game clock and a one-cycle tick strobe. It generalises the fixed 1/2/4/8 divider to any power-of-two rate set and adds four behaviours: glitch-free rate switching, pause, phase restart, and a tick counter. It sits between the board clock and the game-logic FSMs, which consume either `clk_game` or the `tick` enable.

## Interface
- `CNT_W`, 32: width of the internal half-period counter.
- `BASE_HALF`, 12_500_000: half-period, in `clk` cycles, at rate 0.
- `RATE_W`, 2: width of `clk_rate`. Rate r selects a half-period of `BASE_HALF << r`.
- `RATE_RST`, 2: rate loaded at reset. The default gives a half-period of `4*BASE_HALF`.
- `TICK_W`, 16: width of `tick_cnt`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_rate`  in  RATE_W  requested rate. Sampled only at half-period boundaries.
- `pause`  in  1  while high, counter and outputs freeze.
- `restart`  in  1  one-cycle request to restart phase at the start of a low half-period.
- `clk_game`  out  1  divided square wave. Registered.
- `tick`  out  1  one-cycle pulse, high in the first `clk` cycle in which `clk_game` reads 1.
- `tick_cnt`  out  TICK_W  count of ticks since reset. Wraps modulo 2^TICK_W.
- `rate_cur`  out  RATE_W  rate currently in effect.
- `paused`  out  1  registered copy of pause state.

## Operation
- Internal state: `cnt` (CNT_W bits) and `rate_cur`. Half-period length is `HP = BASE_HALF << rate_cur`.
- Elaboration rules:
  - `(BASE_HALF << (2^RATE_W - 1))` must fit in CNT_W bits.
  - `BASE_HALF >= 1`.
  - Violating either rule is a fatal elaboration error.
- Priority per cycle, highest first: `rst`, `restart`, `pause`, normal count.
- `rst` sets:
  - `cnt = 0`, `clk_game = 0`, `tick = 0`, `tick_cnt = 0`
  - `rate_cur = RATE_RST`, `paused = 0`
- `restart` sets:
  - `cnt = 0`, `clk_game = 0`, `tick = 0`
  - `rate_cur = clk_rate`
  - `tick_cnt` unchanged
  - `paused` follows `pause`
- `pause` (no `rst`/`restart`): `cnt`, `clk_game`, `rate_cur` and `tick_cnt` hold; `tick = 0`; `paused = 1`.
- Normal count (`paused = 0`):
  - If `cnt != HP-1`: `cnt = cnt+1`.
  - At the boundary (`cnt == HP-1`):
    - `cnt = 0`
    - `clk_game` toggles
    - `rate_cur = clk_rate`
    - if `clk_game` was 0: `tick = 1` and `tick_cnt = tick_cnt+1`
    - otherwise `tick = 0`
  - On all non-boundary cycles, `tick = 0`.
- Rate changes take effect only at a boundary, so a half-period is never truncated or stretched mid-flight. Each half-period length is set by the rate latched at its start.
- Comparison is an exact equality against `HP-1`, computed at CNT_W bits. No multiplier: the shift is a barrel shift on `rate_cur`.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Output values one cycle after `rst` is sampled high: `clk_game = 0`, `tick = 0`, `tick_cnt = 0`, `rate_cur = RATE_RST`, `paused = 0`.
- Steady state at rate r: `clk_game` period is `2*BASE_HALF<<r` cycles with 50% duty. `tick` fires once per period, coincident with the rising edge of `clk_game`.
- First rising edge after reset or restart (no pause): at cycle HP, counted from the first counting cycle.
- `clk_rate` change latency: takes effect at the next boundary. The worst case is HP(old) cycles.
- Pause:
  - `paused` rises one cycle after `pause` is sampled high.
  - The freeze applies in the same cycle `pause` is sampled.
  - Resume continues from the frozen `cnt`, so pause time is simply inserted into the period.
- `pause` and boundary in the same cycle: pause wins. The toggle happens on the first unpaused cycle.
- `restart` with `pause` both high: restart applies, then the counter stays frozen at 0.
- `tick_cnt` wraps from `2^TICK_W-1` to 0 without a flag.

## Test plan
- **Reset and base rate.** `BASE_HALF=3`, `RATE_RST=0`, release `rst` → `clk_game` toggles every 3 cycles, `tick` is a single-cycle pulse every 6 cycles, `tick_cnt` = 1, 2, 3…
- **Rate switch mid-half-period.** At rate 0, set `clk_rate=2` one cycle after a boundary → the current half-period still lasts 3 cycles, then half-periods are 12; `rate_cur` updates at that boundary.
- **Pause across a boundary.** Hold `pause` for 5 cycles starting at `cnt=2` → `clk_game` holds and `tick` stays 0. The toggle occurs on the first cycle after release. Total period is 6+5 = 11 cycles.
- **Restart.** Pulse `restart` while `clk_game=1`, `cnt=1` → next cycle `clk_game=0`, `cnt=0`, `tick_cnt` unchanged. Next rise comes 3 cycles later.
- **Reset priority.** Assert `rst` together with `restart`, `pause` and a boundary → all outputs at reset values, `rate_cur=RATE_RST`.
- **Wrap.** `TICK_W=3`, run 9 periods → `tick_cnt` sequence 1…7, 0, 1.

Source files
------------

// File: rtl/game_clk_gen.sv
// game_clk_gen
// Divides the system clock into a 50%-duty game clock and a one-cycle tick
// strobe that coincides with each rising edge of the game clock.
// Rate r selects a half-period of (BASE_HALF << r) system clock cycles.
// A new rate is only adopted at a half-period boundary, so no half-period
// is ever truncated or stretched.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   clk_rate  in   requested rate, adopted at the next half-period boundary
//   pause     in   freezes counter and outputs while high
//   restart   in   restarts phase at the beginning of a low half-period
//   clk_game  out  divided square wave (registered)
//   tick      out  one-cycle pulse on each clk_game rising edge (registered)
//   tick_cnt  out  number of ticks since reset, wraps silently
//   rate_cur  out  rate currently in effect
//   paused    out  registered pause state
module game_clk_gen #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned BASE_HALF = 12_500_000,
    parameter int unsigned RATE_W    = 2,
    parameter int unsigned RATE_RST  = 2,
    parameter int unsigned TICK_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] clk_rate,
    input  logic              pause,
    input  logic              restart,
    output logic              clk_game,
    output logic              tick,
    output logic [TICK_W-1:0] tick_cnt,
    output logic [RATE_W-1:0] rate_cur,
    output logic              paused
);

    // Longest half-period, evaluated wide so an overflow of CNT_W is visible.
    localparam logic [63:0] HP_MAX = 64'(BASE_HALF) << ((2 ** RATE_W) - 1);

    if (BASE_HALF < 1) begin : g_bad_base
        $fatal(1, "game_clk_gen: BASE_HALF must be at least 1");
    end

    if ((HP_MAX >> CNT_W) != 64'd0) begin : g_bad_width
        $fatal(1, "game_clk_gen: slowest half-period does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_m1;
    logic             at_boundary;

    // Barrel shift of the base half-period; no multiplier needed.
    assign hp_m1       = (CNT_W'(BASE_HALF) << rate_cur) - CNT_W'(1);
    assign at_boundary = (cnt == hp_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            clk_game <= 1'b0;
            tick     <= 1'b0;
            tick_cnt <= '0;
            rate_cur <= RATE_W'(RATE_RST);
            paused   <= 1'b0;
        end else if (restart) begin
            cnt      <= '0;
            clk_game <= 1'b0;
            tick     <= 1'b0;
            rate_cur <= clk_rate;
            paused   <= pause;
        end else if (pause) begin
            // Pause time is simply inserted into the current half-period.
            tick     <= 1'b0;
            paused   <= 1'b1;
        end else begin
            paused <= 1'b0;
            if (at_boundary) begin
                cnt      <= '0;
                clk_game <= ~clk_game;
                rate_cur <= clk_rate;
                tick     <= ~clk_game;
                if (!clk_game) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_clk_gen.sv
module tb_game_clk_gen;

    localparam int CNT_W     = 32;
    localparam int BASE_HALF = 3;
    localparam int RATE_W    = 2;
    localparam int RATE_RST  = 0;
    localparam int TICK_W    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [RATE_W-1:0] clk_rate;
    logic              pause;
    logic              restart;
    logic              clk_game;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [RATE_W-1:0] rate_cur;
    logic              paused;

    game_clk_gen #(
        .CNT_W    (CNT_W),
        .BASE_HALF(BASE_HALF),
        .RATE_W   (RATE_W),
        .RATE_RST (RATE_RST),
        .TICK_W   (TICK_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_rate(clk_rate),
        .pause   (pause),
        .restart (restart),
        .clk_game(clk_game),
        .tick    (tick),
        .tick_cnt(tick_cnt),
        .rate_cur(rate_cur),
        .paused  (paused)
    );

    always #5 clk = ~clk;

    // Posedge counter; at a negedge it equals the number of the posedge just past.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
        int rate;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_tick(input int c, input int n, input int r);
        exp_t e;
        e.cyc  = c;
        e.cnt  = n % (1 << TICK_W);
        e.rate = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            errors++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, c);
        end
    endtask

    // Monitor: every tick pulse pops one expected tick and compares it.
    always @(negedge clk) begin
        if (!done) begin
            if (tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick at cycle %0d tick_cnt %0d", cyc, tick_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_cnt", int'(tick_cnt), e.cnt);
                    check("tick_rate", int'(rate_cur), e.rate);
                    check("tick_clk_game", int'(clk_game), 1);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_tick: none by cycle %0d, expected at %0d", cyc, e.cyc);
            end
        end
    end

    initial begin
        int t0, t, u, v, w, x;
        rst      = 1'b1;
        clk_rate = '0;
        pause    = 1'b0;
        restart  = 1'b0;

        // Reset values
        wait_cyc(2);
        check("rst_clk_game", int'(clk_game), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_tick_cnt", int'(tick_cnt), 0);
        check("rst_rate_cur", int'(rate_cur), RATE_RST);
        check("rst_paused", int'(paused), 0);

        // Base rate and tick_cnt wrap: 9 periods of 6 cycles
        t0  = cyc;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) push_tick(t0 + 3 + 6 * k, k + 1, 0);
        wait_cyc(t0 + 5);
        check("base_high", int'(clk_game), 1);
        wait_cyc(t0 + 6);
        check("base_fall", int'(clk_game), 0);

        // Rate switch one cycle after a boundary
        t = t0 + 51;
        wait_cyc(t);
        clk_rate = 2'd2;
        push_tick(t + 15, 10, 2);
        push_tick(t + 30, 11, 0);
        wait_cyc(t + 2);
        check("switch_old_rate", int'(rate_cur), 0);
        check("switch_still_high", int'(clk_game), 1);
        wait_cyc(t + 3);
        check("switch_new_rate", int'(rate_cur), 2);
        check("switch_fall", int'(clk_game), 0);
        wait_cyc(t + 16);
        clk_rate = 2'd0;
        wait_cyc(t + 26);
        check("back_old_rate", int'(rate_cur), 2);
        wait_cyc(t + 27);
        check("back_new_rate", int'(rate_cur), 0);

        // Pause for 5 cycles starting at cnt=2, spanning a boundary
        u = t + 30;
        push_tick(u + 11, 12, 0);
        wait_cyc(u + 2);
        pause = 1'b1;
        check("pre_pause_paused", int'(paused), 0);
        wait_cyc(u + 3);
        check("pause_paused", int'(paused), 1);
        wait_cyc(u + 7);
        check("pause_hold", int'(clk_game), 1);
        pause = 1'b0;
        wait_cyc(u + 8);
        check("resume_paused", int'(paused), 0);
        check("resume_fall", int'(clk_game), 0);

        // Restart while clk_game=1, cnt=1
        v = u + 11;
        push_tick(v + 5, 13, 0);
        wait_cyc(v + 1);
        restart = 1'b1;
        wait_cyc(v + 2);
        restart = 1'b0;
        check("restart_clk_game", int'(clk_game), 0);
        check("restart_tick_cnt", int'(tick_cnt), 4);

        // Reset priority over restart, pause and a boundary
        w = v + 5;
        push_tick(w + 9, 14, 1);
        wait_cyc(w);
        clk_rate = 2'd1;
        wait_cyc(w + 3);
        check("rate1_adopted", int'(rate_cur), 1);
        wait_cyc(w + 14);
        rst     = 1'b1;
        restart = 1'b1;
        pause   = 1'b1;
        wait_cyc(w + 15);
        rst      = 1'b0;
        restart  = 1'b0;
        pause    = 1'b0;
        clk_rate = 2'd0;
        check("prio_clk_game", int'(clk_game), 0);
        check("prio_tick", int'(tick), 0);
        check("prio_tick_cnt", int'(tick_cnt), 0);
        check("prio_rate_cur", int'(rate_cur), RATE_RST);
        check("prio_paused", int'(paused), 0);
        push_tick(w + 18, 1, 0);

        // Restart together with pause: counter frozen at 0 until release
        x = w + 18;
        push_tick(x + 7, 2, 0);
        wait_cyc(x);
        restart = 1'b1;
        pause   = 1'b1;
        wait_cyc(x + 1);
        restart = 1'b0;
        check("rp_clk_game", int'(clk_game), 0);
        check("rp_paused", int'(paused), 1);
        wait_cyc(x + 4);
        pause = 1'b0;
        check("rp_frozen", int'(clk_game), 0);

        wait_cyc(x + 12);
        check("pending_ticks", exp_q.size(), 0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
